// File: rtl/i2c_uart_bridge_p.sv
// Write-only I2C slave sampled on the system clock, feeding a FIFO that drains
// through a UART transmitter with optional parity and overflow flow control.
module i2c_uart_bridge_p #(
  parameter logic [6:0]  I2C_ADDR     = 7'h42,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          scl_in,
  input  logic                          sda_in,
  output logic                          sda_oe,
  output logic                          tx,
  input  logic                          overflow_clr,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    I_IDLE, I_ADDR, I_ADDR_ACK, I_DATA, I_DATA_ACK, I_IGNORE
  } i2c_state_e;

  typedef enum logic [2:0] {
    U_IDLE, U_START, U_DATA, U_PARITY, U_STOP
  } uart_state_e;

  // Input conditioning
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   s_scl, s_sda;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  // I2C slave
  i2c_state_e             i2c_state_q, i2c_state_d;
  logic [6:0]             shreg_q, shreg_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   ack_on_q, ack_on_d;
  logic                   ovf_q, ovf_d;
  logic [7:0]             rx_byte;
  logic                   push, drop;

  // FIFO
  logic [7:0]             mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   fifo_full;
  logic [7:0]             rd_data;
  logic                   pop;

  // UART transmitter
  uart_state_e            uart_state_q, uart_state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [2:0]             ubit_q, ubit_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   tx_q, tx_d;
  logic                   baud_end;
  logic                   par_bit;

  assign s_scl     = scl_sync_q[SYNC_STAGES-1];
  assign s_sda     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = s_scl & ~scl_prev_q;
  assign scl_fall  = ~s_scl & scl_prev_q;
  assign start_det = s_scl & scl_prev_q & sda_prev_q & ~s_sda;
  assign stop_det  = s_scl & scl_prev_q & ~sda_prev_q & s_sda;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d = s_scl;
    sda_prev_d = s_sda;
  end

  // START/STOP take priority over any bit activity so a transfer can be
  // abandoned mid-byte; the ACK window opens on the first SCL fall after bit 8
  // and closes on the following fall.
  always_comb begin
    i2c_state_d = i2c_state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    ack_on_d    = ack_on_q;
    push        = 1'b0;
    drop        = 1'b0;
    rx_byte     = {shreg_q, s_sda};
    if (stop_det) begin
      i2c_state_d = I_IDLE;
      ack_on_d    = 1'b0;
    end else if (start_det) begin
      i2c_state_d = I_ADDR;
      bit_cnt_d   = '0;
      ack_on_d    = 1'b0;
    end else begin
      case (i2c_state_q)
        I_ADDR, I_DATA: begin
          if (scl_rise) begin
            shreg_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (i2c_state_q == I_ADDR) begin
                i2c_state_d = (rx_byte[7:1] == I2C_ADDR && !rx_byte[0]) ? I_ADDR_ACK : I_IGNORE;
              end else if (fifo_full) begin
                drop        = 1'b1;
                i2c_state_d = I_IGNORE;
              end else begin
                push        = 1'b1;
                i2c_state_d = I_DATA_ACK;
              end
            end
          end
        end
        I_ADDR_ACK, I_DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              ack_on_d = 1'b1;
            end else begin
              ack_on_d    = 1'b0;
              i2c_state_d = I_DATA;
              bit_cnt_d   = '0;
            end
          end
        end
        default: ;
      endcase
    end
    ovf_d = drop | (ovf_q & ~overflow_clr);
  end

  assign fifo_full = (level_q == LW'(FIFO_DEPTH));
  assign rd_data   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  assign baud_end = (baud_q == CW'(CLKS_PER_BIT - 1));

  // The stop bit pops the next byte on its last cycle so consecutive frames
  // run back to back without an idle cycle in between.
  always_comb begin
    uart_state_d = uart_state_q;
    baud_d       = baud_q;
    ubit_d       = ubit_q;
    tx_byte_d    = tx_byte_q;
    tx_d         = tx_q;
    pop          = 1'b0;
    par_bit      = (PARITY == 2) ? ~(^tx_byte_q) : ^tx_byte_q;
    if (uart_state_q == U_IDLE) begin
      tx_d = 1'b1;
      if (level_q != '0) begin
        pop          = 1'b1;
        tx_byte_d    = rd_data;
        uart_state_d = U_START;
        baud_d       = '0;
        tx_d         = 1'b0;
      end
    end else if (!baud_end) begin
      baud_d = baud_q + CW'(1);
    end else begin
      baud_d = '0;
      case (uart_state_q)
        U_START: begin
          uart_state_d = U_DATA;
          ubit_d       = 3'd0;
          tx_d         = tx_byte_q[0];
        end
        U_DATA: begin
          if (ubit_q == 3'd7) begin
            if (PARITY != 0) begin
              uart_state_d = U_PARITY;
              tx_d         = par_bit;
            end else begin
              uart_state_d = U_STOP;
              tx_d         = 1'b1;
            end
          end else begin
            ubit_d = ubit_q + 3'd1;
            tx_d   = tx_byte_q[ubit_q + 3'd1];
          end
        end
        U_PARITY: begin
          uart_state_d = U_STOP;
          tx_d         = 1'b1;
        end
        default: begin
          if (level_q != '0) begin
            pop          = 1'b1;
            tx_byte_d    = rd_data;
            uart_state_d = U_START;
            tx_d         = 1'b0;
          end else begin
            uart_state_d = U_IDLE;
            tx_d         = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      i2c_state_q  <= I_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      ack_on_q     <= 1'b0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      uart_state_q <= U_IDLE;
      baud_q       <= '0;
      ubit_q       <= '0;
      tx_byte_q    <= '0;
      tx_q         <= 1'b1;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_prev_d;
      sda_prev_q   <= sda_prev_d;
      i2c_state_q  <= i2c_state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      ack_on_q     <= ack_on_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      uart_state_q <= uart_state_d;
      baud_q       <= baud_d;
      ubit_q       <= ubit_d;
      tx_byte_q    <= tx_byte_d;
      tx_q         <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rx_byte;
    end
  end

  assign sda_oe     = ack_on_q;
  assign tx         = tx_q;
  assign overflow   = ovf_q;
  assign fifo_level = level_q;
  assign busy       = (level_q != '0) | (uart_state_q != U_IDLE);

endmodule

// File: tb/tb_i2c_uart_bridge_p.sv
// Drives I2C writes into the bridge and checks ACKs, FIFO level, overflow and
// decoded UART frames against a time-based model of the FIFO and transmitter.
module tb_i2c_uart_bridge_p;

  localparam int C     = 80;  // clocks per UART bit
  localparam int DEPTH = 4;
  localparam int NB    = 11;  // start + 8 data + parity + stop
  localparam int H     = 8;   // SCL half period in clocks
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       reset, scl_in, m_sda, sda_in, sda_oe, tx;
  logic       overflow_clr, overflow, busy;
  logic [2:0] fifo_level;

  assign sda_in = m_sda & ~sda_oe;

  i2c_uart_bridge_p #(
    .I2C_ADDR(7'h42), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(C), .PARITY(2), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe), .tx(tx),
    .overflow_clr(overflow_clr), .overflow(overflow), .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  int         gen = 0;
  logic [8:0] exp_q[$];     // {parity, data} expected on tx
  int         push_e[$];    // clock edge at which each accepted byte enters the FIFO
  int         pop_e[$];     // clock edge at which it leaves for the UART
  bit         ovf_m;
  logic [7:0] payload[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int model_level(input int m);
    int n = 0;
    foreach (push_e[i]) if (push_e[i] <= m) n++;
    foreach (pop_e[i])  if (pop_e[i]  <= m) n--;
    return n;
  endfunction

  // Byte leaves one edge after arrival, or when the previous frame ends.
  function automatic void model_push(input int e);
    int p = e + 1;
    if (pop_e.size() > 0 && pop_e[pop_e.size()-1] + NB * C > p)
      p = pop_e[pop_e.size()-1] + NB * C;
    push_e.push_back(e);
    pop_e.push_back(p);
  endfunction

  function automatic logic odd_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2 == 0);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    push_e.delete();
    pop_e.delete();
    exp_q.delete();
    ovf_m = 1'b0;
    gen++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic i2c_start();
    wait_cyc(2); m_sda = 1'b1;
    wait_cyc(H); scl_in = 1'b1;
    wait_cyc(H); m_sda = 1'b0;
    wait_cyc(H); scl_in = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_cyc(2); m_sda = 1'b0;
    wait_cyc(H); scl_in = 1'b1;
    wait_cyc(H); m_sda = 1'b1;
    wait_cyc(H);
  endtask

  task automatic send_bit(input logic b, output int rise_cyc);
    wait_cyc(2); m_sda = b;
    wait_cyc(H - 2); scl_in = 1'b1; rise_cyc = cyc;
    wait_cyc(H); scl_in = 1'b0;
  endtask

  task automatic i2c_byte(input logic [7:0] b, output int rise8, output logic ack);
    int r = 0;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    rise8 = r;
    wait_cyc(2); m_sda = 1'b1;
    wait_cyc(H - 2); scl_in = 1'b1;
    wait_cyc(H / 2); ack = sda_oe;
    wait_cyc(H / 2); scl_in = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] addr_byte, input bit with_start);
    int   r;
    int   e;
    logic ack;
    logic exp_ack;
    bit   ignoring;
    if (with_start) i2c_start();
    i2c_byte(addr_byte, r, ack);
    ignoring = !((addr_byte[7:1] == 7'h42) && !addr_byte[0]);
    check("addr_ack", ack, !ignoring);
    foreach (payload[i]) begin
      i2c_byte(payload[i], r, ack);
      exp_ack = 1'b0;
      if (!ignoring) begin
        e = r + SYNC + 1;
        if (model_level(e - 1) >= DEPTH) begin
          ovf_m    = 1'b1;
          ignoring = 1'b1;
        end else begin
          model_push(e);
          exp_q.push_back({odd_parity(payload[i]), payload[i]});
          exp_ack = 1'b1;
        end
      end
      check("data_ack", ack, exp_ack);
      check("fifo_level", fifo_level, model_level(cyc));
      check("overflow", overflow, ovf_m);
    end
    i2c_stop();
  endtask

  task automatic clear_overflow();
    @(negedge clk); overflow_clr = 1'b1;
    @(negedge clk); overflow_clr = 1'b0;
    ovf_m = 1'b0;
    check("overflow_clr", overflow, ovf_m);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20 * NB * C) begin
      @(negedge clk);
      n++;
    end
    check("drain_busy", busy, 0);
    wait_cyc(4);
    check("drain_level", fifo_level, 0);
    check("drain_scoreboard", exp_q.size(), 0);
  endtask

  // UART monitor: decode each frame at mid-bit and score it.
  initial begin
    int         g;
    logic [7:0] d;
    logic       p, s0, s1;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        g = gen;
        wait_cyc(C / 2); s0 = tx;
        for (int i = 0; i < 8; i++) begin
          wait_cyc(C); d[i] = tx;
        end
        wait_cyc(C); p  = tx;
        wait_cyc(C); s1 = tx;
        if (g == gen) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected actual=%0h expected=none", {p, d});
          end else begin
            e = exp_q.pop_front();
            check("tx_frame", {p, d}, e);
            check("tx_framing", {s0, s1}, 2'b01);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] a;
    int         n;
    int         lows;
    reset = 1'b1; scl_in = 1'b1; m_sda = 1'b1; overflow_clr = 1'b0; ovf_m = 1'b0;
    wait_cyc(3);
    reset = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_overflow", overflow, 0);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 0);

    // Basic write to own address
    payload.delete(); payload.push_back(8'hA5);
    do_write(8'h84, 1'b1);
    wait_idle();

    // Foreign address: nothing acknowledged or stored
    payload.delete();
    payload.push_back(8'h11); payload.push_back(8'h22); payload.push_back(8'h33);
    do_write(8'h86, 1'b1);
    wait_idle();

    // Six bytes against a four-deep FIFO while the UART is slow
    payload.delete();
    for (int i = 1; i <= 6; i++) payload.push_back(8'(i));
    do_write(8'h84, 1'b1);
    check("overflow_set", overflow, 1);
    clear_overflow();
    wait_idle();

    // Repeated START after four bits of a data byte
    begin
      int   r;
      logic ack;
      i2c_start();
      i2c_byte(8'h84, r, ack);
      check("rs_addr_ack", ack, 1);
      send_bit(1'b1, r); send_bit(1'b0, r); send_bit(1'b1, r); send_bit(1'b1, r);
    end
    payload.delete(); payload.push_back(8'h3C);
    do_write(8'h84, 1'b1);
    wait_idle();

    // Odd parity on 0x07 gives parity bit 0
    payload.delete(); payload.push_back(8'h07);
    do_write(8'h84, 1'b1);
    wait_idle();

    // Reset during a UART data bit with two bytes still queued
    payload.delete();
    payload.push_back(8'hA1); payload.push_back(8'hB2); payload.push_back(8'hC3);
    do_write(8'h84, 1'b1);
    n = 0;
    while (pop_e.size() > 0 && cyc < pop_e[0] + 5 * C && n < 4 * NB * C) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_level", fifo_level, model_level(cyc));
    do_reset();
    check("post_reset_tx", tx, 1);
    check("post_reset_level", fifo_level, 0);
    check("post_reset_busy", busy, 0);
    check("post_reset_sda_oe", sda_oe, 0);
    lows = 0;
    repeat (3 * NB * C) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("post_reset_quiet", lows, 0);

    // Randomised transactions
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(0, 9);
      if (n < 7)       a = 8'h84;
      else if (n == 7) a = 8'h86;
      else if (n == 8) a = 8'h85;
      else             a = 8'h40;
      payload.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
      do_write(a, 1'b1);
      if ($urandom_range(0, 2) == 0) clear_overflow();
      wait_cyc($urandom_range(0, 900));
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_uart_bridge_p.md
Name: i2c_uart_bridge_p

Overview:
- Parametrised, single-clock successor to the SCL-clocked I2C-to-UART bridge.
- Samples SCL/SDA on a system clock and acts as an addressed, write-only I2C slave with ACK/NACK.
- Buffers received bytes in a FIFO of configurable depth.
- Drains the FIFO through a UART transmitter with configurable baud divider and optional parity.
- Adds address filtering, NACK-on-full flow control, and overflow/level status that the previous bridge lacked.

Parameters:
- I2C_ADDR, 7'h42, 7-bit slave address matched after START.
- FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 2.
- CLKS_PER_BIT, 87, clk cycles per UART bit; minimum 4.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in; minimum 2.

Ports:
- clk  in  1  system clock; must be at least 8x the SCL frequency.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  raw I2C SCL.
- sda_in  in  1  raw I2C SDA.
- sda_oe  out  1  1 = pull SDA low (open-drain, external pad).
- tx  out  1  UART serial output, idle high.
- overflow_clr  in  1  1-cycle pulse clears overflow.
- overflow  out  1  sticky: a byte was NACKed because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  FIFO non-empty or UART not idle.

Behaviour:
- Reset, one clk edge with reset=1:
  - sda_oe=0, tx=1, overflow=0, fifo_level=0, busy=0.
  - Both FSMs go to IDLE and FIFO pointers clear.
  - A frame in progress is aborted silently: a UART frame cut short, an I2C transfer left un-ACKed.
- Input conditioning:
  - scl_in and sda_in each pass through SYNC_STAGES flops; s_scl/s_sda are the last stage.
  - Edge detects compare the last stage against one extra history flop.
- Bus conditions:
  - START = s_sda falls while s_scl=1 and s_scl was 1 in the previous cycle.
  - STOP = s_sda rises under the same condition.
  - START or STOP is honoured in any I2C state, including mid-byte.
- I2C FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
  - IDLE -> ADDR on START.
  - Bits are shifted MSB first on each s_scl rising edge; a 3-bit counter counts 8 bits.
  - ADDR, after 8 bits: if addr==I2C_ADDR and R/W=0 -> ADDR_ACK; otherwise -> IGNORE with no ACK.
  - ADDR_ACK: sda_oe=1 from the first s_scl falling edge after bit 8 until the next s_scl falling edge, then -> DATA.
  - DATA, after 8 bits, the FIFO-full check is made on the s_scl rising edge of bit 8:
    - FIFO not full: push the byte (one-cycle write) and go to DATA_ACK, which drives ACK exactly as ADDR_ACK does, then -> DATA.
    - FIFO full: drop the byte, set overflow, no ACK, -> IGNORE.
  - IGNORE: sda_oe=0; leave only on START (-> ADDR) or STOP (-> IDLE).
  - Repeated START from any state -> ADDR. STOP from any state -> IDLE with sda_oe=0 in the next cycle.
- FIFO:
  - Synchronous, one write port and one read port; level is updated on the same edge as the push or pop.
  - A simultaneous push and pop leaves the level unchanged; a pop is legal when level>=1.
  - Pointers wrap modulo FIFO_DEPTH. A push when full is impossible by construction.
- UART FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE with level>0: pop in that cycle, latch the byte, -> START. tx=0 on the following edge.
  - Latency: a FIFO write at cycle N with the UART idle gives a pop at N+1 and tx=0 from N+2.
  - Each bit lasts exactly CLKS_PER_BIT cycles. Data goes out LSB first, 8 bits.
  - PARITY state is skipped when PARITY=0. The parity bit is even or odd over the 8 data bits.
  - STOP: tx=1 for one bit time, then -> IDLE. Back-to-back frames have no extra idle cycles.
- overflow: set on a dropped byte. It is cleared by overflow_clr. If set and clear occur in the same cycle, set wins.
- busy = (level!=0) | (UART state!=IDLE).

Test Plan:
- CLKS_PER_BIT=8, PARITY=0: START, addr 0x42+W, data 0xA5, STOP.
  - ACK on both bytes; fifo_level pulses to 1.
  - tx shows 0,1,0,1,0,0,1,0,1,1 at 8-cycle bit times; busy drops after stop.
- Address 0x43+W, then 3 data bytes.
  - No ACK anywhere; fifo_level stays 0; FSM in IGNORE until STOP.
- FIFO_DEPTH=4, UART held busy by a long CLKS_PER_BIT, write 6 bytes 0x01..0x06.
  - Bytes 1-5 ACKed: one is popped immediately, 4 are buffered.
  - Byte 6 NACKed and overflow=1; tx later emits 0x01..0x05 in order.
  - overflow_clr -> overflow=0.
- Repeated START mid-data-byte after 4 bits, then addr 0x42+W, data 0x3C.
  - The partial byte is discarded; only 0x3C is pushed and transmitted.
- PARITY=2: send 0x07. tx frame is start, 1,1,1,0,0,0,0,0, parity=0, stop.
- Assert reset during a UART data bit with 2 bytes queued.
  - Next edge: tx=1, fifo_level=0, busy=0, sda_oe=0.
  - No further tx activity until a new I2C write.
